// File: rtl/d_wb_arbiter.sv
//==============================================================================
// Module      : d_wb_arbiter
// Description : Write-back arbiter and RAW scoreboard for the single write
//               port of the register bank. NUM_REQ producers share the port
//               through a valid/ready handshake; the winner's address and data
//               are registered into the bank write stage one cycle later.
//               Build option: define D_WB_FIXED_PRIO_EN for fixed priority
//               (lowest index wins) instead of round-robin.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module d_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DW      = 32,
  parameter int AW      = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NUM_REQ-1:0]    i_wb_valid,
  output logic [NUM_REQ-1:0]    o_wb_ready,
  input  logic [NUM_REQ*AW-1:0] i_wb_addr,
  input  logic [NUM_REQ*DW-1:0] i_wb_data,
  input  logic                  i_resv_valid,
  input  logic [AW-1:0]         i_resv_addr,
  input  logic [AW-1:0]         i_addr_Rs,
  input  logic [AW-1:0]         i_addr_Rt,
  output logic                  o_busy_Rs,
  output logic                  o_busy_Rt,
  output logic                  o_con_RegWr,
  output logic [AW-1:0]         o_addr_Rd,
  output logic [DW-1:0]         o_data_Rd,
  output logic [(1<<AW)-1:0]    o_pending
);

  localparam int c_NREG = 1 << AW;

  logic [NUM_REQ-1:0] w_grant;
  logic               w_xfer;
  logic [AW-1:0]      w_sel_addr;
  logic [DW-1:0]      w_sel_data;

  logic               r_we;
  logic [AW-1:0]      r_addr;
  logic [DW-1:0]      r_data;
  logic [c_NREG-1:0]  r_pending;
  logic [c_NREG-1:0]  w_pending_nxt;

`ifdef D_WB_FIXED_PRIO_EN

  // Fixed priority: the lowest-indexed valid requester is granted
  always_comb begin
    w_grant = '0;
    w_xfer  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_xfer && i_wb_valid[i]) begin
        w_xfer     = 1'b1;
        w_grant[i] = 1'b1;
      end
    end
  end

`else

  localparam int             c_PW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int             c_PW1 = c_PW + 1;
  localparam logic [c_PW:0]  c_NUM = c_PW1'(NUM_REQ);
  localparam logic [c_PW-1:0] c_LAST = c_PW'(NUM_REQ - 1);

  logic [c_PW-1:0] r_rr_ptr;
  logic [c_PW-1:0] w_idx;
  logic [c_PW:0]   w_j;

  // Round-robin search starting at r_rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    w_grant = '0;
    w_xfer  = 1'b0;
    w_idx   = '0;
    w_j     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_j = {1'b0, r_rr_ptr} + c_PW1'(i);
      if (w_j >= c_NUM) begin
        w_j = w_j - c_NUM;
      end
      if (!w_xfer && i_wb_valid[w_j[c_PW-1:0]]) begin
        w_xfer                   = 1'b1;
        w_idx                    = w_j[c_PW-1:0];
        w_grant[w_j[c_PW-1:0]]   = 1'b1;
      end
    end
  end

  // Pointer moves just past the winner on a transfer, holds otherwise
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_xfer) begin
      r_rr_ptr <= (w_idx == c_LAST) ? '0 : w_idx + 1'b1;
    end
  end

`endif

  // Bank always accepts, so the grant vector is the ready vector
  assign o_wb_ready = w_grant;

  // Select the winning requester's address and data from the packed buses
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_grant[k]) begin
        w_sel_addr = i_wb_addr[k*AW +: AW];
        w_sel_data = i_wb_data[k*DW +: DW];
      end
    end
  end

  // Registered bank write stage; writes to $zero are consumed but suppressed
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_we <= w_xfer && (w_sel_addr != '0);
      if (w_xfer) begin
        r_addr <= w_sel_addr;
        r_data <= w_sel_data;
      end
    end
  end

  // Scoreboard update: clear on write transfer, set on reservation (set wins)
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_xfer) begin
      w_pending_nxt = w_pending_nxt & ~(c_NREG'(1) << w_sel_addr);
    end
    if (i_resv_valid) begin
      w_pending_nxt = w_pending_nxt | (c_NREG'(1) << i_resv_addr);
    end
    w_pending_nxt[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  // Busy covers both outstanding producers and the in-flight bank write
  always_comb begin
    o_busy_Rs = (i_addr_Rs != '0) &&
                (r_pending[i_addr_Rs] || (r_we && (r_addr == i_addr_Rs)));
    o_busy_Rt = (i_addr_Rt != '0) &&
                (r_pending[i_addr_Rt] || (r_we && (r_addr == i_addr_Rt)));
  end

  assign o_con_RegWr = r_we;
  assign o_addr_Rd   = r_addr;
  assign o_data_Rd   = r_data;
  assign o_pending   = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_d_wb_arbiter.sv
//==============================================================================
// Module      : tb_d_wb_arbiter
// Description : Directed self-checking bench for d_wb_arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_d_wb_arbiter;

  localparam int NUM_REQ = 3;
  localparam int DW      = 32;
  localparam int AW      = 5;

  logic                  i_clk = 1'b0;
  logic                  i_rst_n;
  logic [NUM_REQ-1:0]    i_wb_valid;
  logic [NUM_REQ-1:0]    o_wb_ready;
  logic [NUM_REQ*AW-1:0] i_wb_addr;
  logic [NUM_REQ*DW-1:0] i_wb_data;
  logic                  i_resv_valid;
  logic [AW-1:0]         i_resv_addr;
  logic [AW-1:0]         i_addr_Rs;
  logic [AW-1:0]         i_addr_Rt;
  logic                  o_busy_Rs;
  logic                  o_busy_Rt;
  logic                  o_con_RegWr;
  logic [AW-1:0]         o_addr_Rd;
  logic [DW-1:0]         o_data_Rd;
  logic [31:0]           o_pending;

  int errors = 0;
  int checks = 0;

  d_wb_arbiter #(.NUM_REQ(NUM_REQ), .DW(DW), .AW(AW)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_wb_valid   (i_wb_valid),
    .o_wb_ready   (o_wb_ready),
    .i_wb_addr    (i_wb_addr),
    .i_wb_data    (i_wb_data),
    .i_resv_valid (i_resv_valid),
    .i_resv_addr  (i_resv_addr),
    .i_addr_Rs    (i_addr_Rs),
    .i_addr_Rt    (i_addr_Rt),
    .o_busy_Rs    (o_busy_Rs),
    .o_busy_Rt    (o_busy_Rt),
    .o_con_RegWr  (o_con_RegWr),
    .o_addr_Rd    (o_addr_Rd),
    .o_data_Rd    (o_data_Rd),
    .o_pending    (o_pending)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    i_rst_n      = 1'b0;
    i_wb_valid   = '0;
    i_wb_addr    = '0;
    i_wb_data    = '0;
    i_resv_valid = 1'b0;
    i_resv_addr  = '0;
    i_addr_Rs    = '0;
    i_addr_Rt    = '0;

    // Reset state
    tick();
    tick();
    check("rst_we",    o_con_RegWr, 0);
    check("rst_addr",  o_addr_Rd,   0);
    check("rst_data",  o_data_Rd,   0);
    check("rst_pend",  o_pending,   0);
    check("rst_ready", o_wb_ready,  0);
    i_rst_n = 1'b1;

    // Single write from requester 1
    i_wb_valid = 3'b010;
    i_wb_addr[1*AW +: AW] = 5'd5;
    i_wb_data[1*DW +: DW] = 32'hDEADBEEF;
    #1;
    check("single_ready", o_wb_ready, 3'b010);
    tick();
    i_wb_valid = '0;
    check("single_we",   o_con_RegWr, 1);
    check("single_addr", o_addr_Rd,   5);
    check("single_data", o_data_Rd,   32'hDEADBEEF);
    tick();
    check("single_we_off", o_con_RegWr, 0);
    check("single_hold",   o_addr_Rd,   5);

    // Fairness from a fresh reset
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    i_wb_valid = 3'b111;
    i_wb_addr  = {5'd3, 5'd2, 5'd1};
    i_wb_data  = {32'h3333, 32'h2222, 32'h1111};
    for (int c = 0; c < 6; c++) begin
      #1;
`ifdef D_WB_FIXED_PRIO_EN
      check("fair_ready", o_wb_ready, 3'b001);
      tick();
      check("fair_addr", o_addr_Rd, 1);
`else
      check("fair_ready", o_wb_ready, 3'b001 << (c % 3));
      tick();
      check("fair_addr", o_addr_Rd, (c % 3) + 1);
`endif
      check("fair_we", o_con_RegWr, 1);
    end
    i_wb_valid = '0;
    tick();

    // $zero write is consumed but not performed
    i_wb_valid = 3'b001;
    i_wb_addr[0 +: AW] = 5'd0;
    i_wb_data[0 +: DW] = 32'h1234;
    #1;
    check("zero_ready", o_wb_ready, 3'b001);
    tick();
    i_wb_valid = '0;
    check("zero_we",   o_con_RegWr, 0);
    check("zero_data", o_data_Rd,   32'h1234);
    i_wb_valid = 3'b011;
    #1;
`ifdef D_WB_FIXED_PRIO_EN
    check("zero_rr_adv", o_wb_ready, 3'b001);
`else
    check("zero_rr_adv", o_wb_ready, 3'b010);
`endif
    i_wb_valid = '0;

    // Scoreboard reserve, write, and in-flight coverage
    i_addr_Rs    = 5'd8;
    i_addr_Rt    = 5'd8;
    i_resv_valid = 1'b1;
    i_resv_addr  = 5'd8;
    #1;
    check("sb_busy_pre", o_busy_Rs, 0);
    tick();
    i_resv_valid = 1'b0;
    check("sb_busy_rs",  o_busy_Rs, 1);
    check("sb_busy_rt",  o_busy_Rt, 1);
    check("sb_pend",     o_pending, 32'h100);
    i_wb_valid = 3'b100;
    i_wb_addr[2*AW +: AW] = 5'd8;
    i_wb_data[2*DW +: DW] = 32'hCAFE;
    #1;
    check("sb_ready", o_wb_ready, 3'b100);
    tick();
    i_wb_valid = '0;
    check("sb_pend_clr",  o_pending,   0);
    check("sb_we",        o_con_RegWr, 1);
    check("sb_busy_fly",  o_busy_Rs,   1);
    tick();
    check("sb_busy_done", o_busy_Rs,   0);
    check("sb_busy_rt0",  o_busy_Rt,   0);

    // Reserving $zero never sets a pending bit
    i_resv_valid = 1'b1;
    i_resv_addr  = 5'd0;
    i_addr_Rs    = 5'd0;
    tick();
    check("zero_resv_pend", o_pending, 0);
    check("zero_resv_busy", o_busy_Rs, 0);

    // Same-edge set and clear of address 9: set wins
    i_resv_addr = 5'd9;
    tick();
    check("col_pend_pre", o_pending, 32'h200);
    i_wb_valid = 3'b001;
    i_wb_addr[0 +: AW] = 5'd9;
    i_wb_data[0 +: DW] = 32'h99;
    tick();
    i_wb_valid = '0;
    check("col_pend", o_pending, 32'h200);
    check("col_addr", o_addr_Rd, 9);

    // Build pending = 0xF00 and an in-flight write, then reset
    i_resv_addr = 5'd8;
    tick();
    i_resv_addr = 5'd10;
    tick();
    i_resv_addr = 5'd11;
    tick();
    i_resv_valid = 1'b0;
    i_wb_valid = 3'b010;
    i_wb_addr[1*AW +: AW] = 5'd1;
    i_wb_data[1*DW +: DW] = 32'h5555;
    tick();
    i_wb_valid = '0;
    check("mid_pend", o_pending,   32'h0F00);
    check("mid_we",   o_con_RegWr, 1);
    i_rst_n      = 1'b0;
    i_wb_valid   = 3'b111;
    i_resv_valid = 1'b1;
    i_resv_addr  = 5'd12;
    tick();
    check("mid_rst_pend", o_pending,   0);
    check("mid_rst_we",   o_con_RegWr, 0);
    check("mid_rst_addr", o_addr_Rd,   0);
    check("mid_rst_data", o_data_Rd,   0);
    i_rst_n      = 1'b1;
    i_resv_valid = 1'b0;
    #1;
    check("mid_rst_grant", o_wb_ready, 3'b001);
    i_wb_valid = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
